// File: rtl/crypto_pkg.sv
// Shared types and constants for the scalar-crypto sequencer: FSM encoding,
// crypto-vector field positions and the default abort budget.
package crypto_pkg;

  localparam int VEC_W  = 20;
  localparam int OP_W   = 18;
  localparam int BS_MSB = 19;
  localparam int BS_LSB = 18;
  localparam int OP_MSB = 17;
  localparam int OP_LSB = 0;

  // Extremes of decode's one-hot op ordering.
  localparam int OP_SAES32_ENCS = 17;
  localparam int OP_SSM4_ED     = 0;

  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/crypto_op_legal.sv
// Exactly-one-hot check of the decoded crypto op flags.
// Purely combinational, zero latency, no flow control.
module crypto_op_legal
  import crypto_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output logic            legal
);

  // x & (x-1) clears the lowest set bit; zero afterwards means at most one bit was set.
  assign legal = (op != '0) && ((op & (op - OP_W'(1))) == '0);

endmodule

// File: rtl/crypto_seq_ctrl.sv
// Sequences one scalar-crypto op through the shared unit (req/ack/done) and writes its result back.
// Min 2 cycles of stall (issue, ack+done); decode is stalled until commit; load writeback holds the WB slot.
module crypto_seq_ctrl
  import crypto_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [VEC_W-1:0]  crypto_instruction,
  input  logic [31:0]       rs1_val,
  input  logic [31:0]       rs2_val,
  input  logic [4:0]        rd_in,
  output logic              stall_o,
  output logic              cu_req,
  output logic [OP_W-1:0]   cu_op,
  output logic [1:0]        cu_bs,
  output logic [31:0]       cu_rs1,
  output logic [31:0]       cu_rs2,
  input  logic              cu_ack,
  input  logic              cu_done,
  input  logic [31:0]       cu_result,
  input  logic              load_wb,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              err_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            res_valid_q;
  logic [4:0]      rd_q;
  logic [31:0]     res_q;
  logic            req_q;
  logic            err_q;
  logic            legal;
  logic            accept, bad, take_res, tmo, tmo_hit, commit;

  crypto_op_legal u_legal (
    .op    (crypto_instruction[OP_MSB:OP_LSB]),
    .legal (legal)
  );

  assign tmo_hit = (cnt_q == CNT_MAX);
  assign commit  = !(res_valid_q && load_wb);

  always_comb begin
    state_d  = state_q;
    stall_o  = 1'b0;
    wb_we    = 1'b0;
    accept   = 1'b0;
    bad      = 1'b0;
    take_res = 1'b0;
    tmo      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue_valid) begin
          if (legal) begin
            stall_o = 1'b1;
            accept  = 1'b1;
            state_d = ST_REQ;
          end else begin
            bad = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stall_o = 1'b1;
        if (cu_ack && cu_done) begin
          take_res = 1'b1;
          state_d  = ST_WB;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          state_d = ST_WB;
        end else if (cu_ack) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_o = 1'b1;
        // A done arriving in the expiry cycle still delivers its result.
        if (cu_done) begin
          take_res = 1'b1;
          state_d  = ST_WB;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        if (commit) begin
          wb_we   = res_valid_q && (rd_q != 5'd0);
          state_d = ST_IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      rd_q        <= '0;
      res_q       <= '0;
      cu_op       <= '0;
      cu_bs       <= '0;
      cu_rs1      <= '0;
      cu_rs2      <= '0;
      req_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == ST_REQ);
      err_q   <= bad || tmo;
      if (accept) begin
        cu_op       <= crypto_instruction[OP_MSB:OP_LSB];
        cu_bs       <= crypto_instruction[BS_MSB:BS_LSB];
        cu_rs1      <= rs1_val;
        cu_rs2      <= rs2_val;
        rd_q        <= rd_in;
        cnt_q       <= '0;
        res_valid_q <= 1'b0;
      end else if ((state_q == ST_REQ || state_q == ST_WAIT) && !tmo_hit) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (take_res) begin
        res_q       <= cu_result;
        res_valid_q <= 1'b1;
      end else if (tmo) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign cu_req  = req_q;
  assign err_o   = err_q;
  assign wb_rd   = rd_q;
  assign wb_data = res_q;

endmodule

// File: tb/tb_crypto_seq_ctrl.sv
// Directed bench for crypto_seq_ctrl with a 4-cycle abort budget; inputs change
// 1ns after the rising edge and outputs are compared on the falling edge.
module tb_crypto_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [19:0] crypto_instruction;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_in;
  logic        stall_o, cu_req;
  logic [17:0] cu_op;
  logic [1:0]  cu_bs;
  logic [31:0] cu_rs1, cu_rs2;
  logic        cu_ack, cu_done;
  logic [31:0] cu_result;
  logic        load_wb;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_o;

  logic [3:0]  ctl;
  int          errors = 0;
  int          checks = 0;

  assign ctl = {stall_o, cu_req, wb_we, err_o};

  crypto_seq_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .issue_valid        (issue_valid),
    .crypto_instruction (crypto_instruction),
    .rs1_val            (rs1_val),
    .rs2_val            (rs2_val),
    .rd_in              (rd_in),
    .stall_o            (stall_o),
    .cu_req             (cu_req),
    .cu_op              (cu_op),
    .cu_bs              (cu_bs),
    .cu_rs1             (cu_rs1),
    .cu_rs2             (cu_rs2),
    .cu_ack             (cu_ack),
    .cu_done            (cu_done),
    .cu_result          (cu_result),
    .load_wb            (load_wb),
    .wb_we              (wb_we),
    .wb_rd              (wb_rd),
    .wb_data            (wb_data),
    .err_o              (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  // ctl = {stall_o, cu_req, wb_we, err_o}
  task automatic test_reset();
    issue_valid = 0; crypto_instruction = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
    cu_ack = 0; cu_done = 0; cu_result = '0; load_wb = 0;
    do_reset();
    @(negedge clk);
    checks++;
    if (ctl !== 4'b0000) begin errors++; $display("FAIL reset_ctl: got %b want 0000", ctl); end
    checks++;
    if ({cu_op, cu_bs, wb_rd, wb_data} !== '0) begin
      errors++; $display("FAIL reset_latches: op=%h bs=%b rd=%0d data=%h want all 0", cu_op, cu_bs, wb_rd, wb_data);
    end
    next_cycle();
  endtask

  task automatic test_aes(input int hold, input string tag);
    issue_valid = 1; crypto_instruction = 20'hE0000;
    rs1_val = 32'h00112233; rs2_val = 32'h44556677; rd_in = 5'd10; load_wb = 0;
    @(negedge clk);
    checks++;
    if (ctl !== 4'b1000) begin errors++; $display("FAIL %s_issue_ctl: got %b want 1000", tag, ctl); end
    next_cycle();
    cu_ack = 1;
    @(negedge clk);
    checks++;
    if (ctl !== 4'b1100) begin errors++; $display("FAIL %s_req_ctl: got %b want 1100", tag, ctl); end
    checks++;
    if ({cu_op, cu_bs} !== {18'h20000, 2'b11}) begin
      errors++; $display("FAIL %s_op_bs: got op=%h bs=%b want op=20000 bs=11", tag, cu_op, cu_bs);
    end
    checks++;
    if ({cu_rs1, cu_rs2} !== {32'h00112233, 32'h44556677}) begin
      errors++; $display("FAIL %s_operands: got %h %h want 00112233 44556677", tag, cu_rs1, cu_rs2);
    end
    next_cycle();
    cu_ack = 0;
    @(negedge clk);
    checks++;
    if (ctl !== 4'b1000) begin errors++; $display("FAIL %s_wait_ctl: got %b want 1000", tag, ctl); end
    next_cycle();
    cu_done = 1; cu_result = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (ctl !== 4'b1000) begin errors++; $display("FAIL %s_done_ctl: got %b want 1000", tag, ctl); end
    next_cycle();
    cu_done = 0; cu_result = '0;
    for (int i = 0; i < hold; i++) begin
      load_wb = 1;
      @(negedge clk);
      checks++;
      if (ctl !== 4'b1000) begin errors++; $display("FAIL %s_held_ctl%0d: got %b want 1000", tag, i, ctl); end
      next_cycle();
    end
    load_wb = 0;
    @(negedge clk);
    checks++;
    if (ctl !== 4'b0010) begin errors++; $display("FAIL %s_wb_ctl: got %b want 0010", tag, ctl); end
    checks++;
    if ({wb_rd, wb_data} !== {5'd10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL %s_wb_dat: got rd=%0d data=%h want rd=10 data=deadbeef", tag, wb_rd, wb_data);
    end
    next_cycle();
    issue_valid = 0;
    @(negedge clk);
    checks++;
    if (ctl !== 4'b0000) begin errors++; $display("FAIL %s_idle_ctl: got %b want 0000", tag, ctl); end
    next_cycle();
  endtask

  task automatic test_illegal();
    issue_valid = 1; crypto_instruction = 20'h00003; rd_in = 5'd7;
    @(negedge clk);
    checks++;
    if (ctl !== 4'b0000) begin errors++; $display("FAIL illegal_issue_ctl: got %b want 0000", ctl); end
    next_cycle();
    issue_valid = 0;
    @(negedge clk);
    checks++;
    if (ctl !== 4'b0001) begin errors++; $display("FAIL illegal_err_ctl: got %b want 0001", ctl); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (ctl !== 4'b0000) begin errors++; $display("FAIL illegal_after_ctl: got %b want 0000", ctl); end
    next_cycle();
  endtask

  task automatic test_timeout();
    int err_cnt;
    int stall_low;
    err_cnt = 0; stall_low = 0;
    issue_valid = 1; crypto_instruction = 20'h00001; rd_in = 5'd5;
    rs1_val = 32'hA5A5A5A5; rs2_val = 32'h5A5A5A5A;
    next_cycle();
    cu_ack = 1;
    @(negedge clk);
    checks++;
    if (ctl !== 4'b1100) begin errors++; $display("FAIL tmo_req_ctl: got %b want 1100", ctl); end
    next_cycle();
    cu_ack = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== 4'b1000) begin errors++; $display("FAIL tmo_wait_ctl%0d: got %b want 1000", i, ctl); end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (ctl !== 4'b0001) begin errors++; $display("FAIL tmo_wb_ctl: got %b want 0001", ctl); end
    next_cycle();
    // Next instruction must be accepted at once, proving the sequencer is back in IDLE.
    crypto_instruction = 20'h00800; rd_in = 5'd3;
    @(negedge clk);
    checks++;
    if (ctl !== 4'b1000) begin errors++; $display("FAIL tmo_idle_ctl: got %b want 1000", ctl); end
    do_reset();
    issue_valid = 0;
  endtask

  task automatic test_rd_zero();
    issue_valid = 1; crypto_instruction = 20'h00800; rd_in = 5'd0;
    rs1_val = 32'h0000FFFF; rs2_val = 32'h0;
    next_cycle();
    cu_ack = 1; cu_done = 1; cu_result = 32'h12345678;
    @(negedge clk);
    checks++;
    if (ctl !== 4'b1100) begin errors++; $display("FAIL rd0_req_ctl: got %b want 1100", ctl); end
    checks++;
    if (cu_op !== 18'h00800) begin errors++; $display("FAIL rd0_op: got %h want 00800", cu_op); end
    next_cycle();
    cu_ack = 0; cu_done = 0; cu_result = '0;
    @(negedge clk);
    checks++;
    if (ctl !== 4'b0000) begin errors++; $display("FAIL rd0_wb_ctl: got %b want 0000", ctl); end
    checks++;
    if ({wb_rd, wb_data} !== {5'd0, 32'h12345678}) begin
      errors++; $display("FAIL rd0_wb_dat: got rd=%0d data=%h want rd=0 data=12345678", wb_rd, wb_data);
    end
    next_cycle();
    issue_valid = 0;
    next_cycle();
  endtask

  task automatic test_reset_mid_op();
    issue_valid = 1; crypto_instruction = 20'h40100; rd_in = 5'd9;
    rs1_val = 32'hCAFEF00D; rs2_val = 32'h0BADC0DE;
    next_cycle();
    cu_ack = 1;
    next_cycle();
    cu_ack = 0;
    @(negedge clk);
    checks++;
    if (ctl !== 4'b1000) begin errors++; $display("FAIL rst_mid_wait_ctl: got %b want 1000", ctl); end
    issue_valid = 0;
    do_reset();
    cu_done = 1; cu_result = 32'h77777777;
    @(negedge clk);
    checks++;
    if (ctl !== 4'b0000) begin errors++; $display("FAIL rst_mid_ctl: got %b want 0000", ctl); end
    checks++;
    if ({cu_op, cu_bs, cu_rs1, cu_rs2, wb_rd, wb_data} !== '0) begin
      errors++; $display("FAIL rst_mid_latches: op=%h bs=%b rs1=%h rs2=%h rd=%0d data=%h want all 0",
                         cu_op, cu_bs, cu_rs1, cu_rs2, wb_rd, wb_data);
    end
    next_cycle();
    cu_done = 0; cu_result = '0;
    @(negedge clk);
    checks++;
    if ({ctl, wb_data} !== {4'b0000, 32'h0}) begin
      errors++; $display("FAIL rst_mid_late_done: got ctl=%b data=%h want 0000 00000000", ctl, wb_data);
    end
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_aes(0, "aes");
    test_aes(2, "loadwb");
    test_illegal();
    test_timeout();
    test_rd_zero();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
